// File: rtl/div_restoring_seq_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_e        : FSM state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH  : default operand width
//   cnt_width()    : iteration counter width for a given operand width
package div_restoring_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // The counter only has to hold WIDTH-1; keep at least one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    int unsigned n;
    n = $clog2(w);
    return (n < 1) ? 1 : n;
  endfunction

  localparam int unsigned DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/div_restoring_seq_sub_stage.sv
// Ripple subtract stage: diff = minuend - subtrahend, with no borrow-in.
// Implemented as minuend + ~subtrahend + 1; borrow_out is the inverted
// final carry.
//   minuend    in  W   left operand
//   subtrahend in  W   right operand
//   diff       out W   modulo-2^W difference
//   borrow_out out 1   1 when subtrahend > minuend
module div_restoring_seq_sub_stage #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] minuend,
  input  logic [W-1:0] subtrahend,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  always_comb begin
    logic c;
    logic nb;
    diff = '0;
    c    = 1'b1;
    for (int unsigned i = 0; i < W; i++) begin
      nb      = ~subtrahend[i];
      diff[i] = minuend[i] ^ nb ^ c;
      c       = (minuend[i] & nb) | (c & (minuend[i] ^ nb));
    end
    borrow_out = ~c;
  end

endmodule

// File: rtl/div_restoring_seq.sv
// Sequential restoring divider: unsigned quotient and remainder over WIDTH
// iteration cycles using a single WIDTH+1-bit ripple subtract stage.
//   clk, rst_n   clock, asynchronous active-low reset
//   start        request, sampled only in IDLE
//   dividend     captured on accepted start
//   divisor      captured on accepted start
//   busy         high whenever the FSM is not in IDLE
//   done         one-cycle pulse, results valid
//   quotient     result quotient, held until the next accepted start
//   remainder    result remainder, held until the next accepted start
//   div_by_zero  set with done on a zero divisor (DIV_ZERO_DETECT_EN only)
// Build option: define DIV_ZERO_DETECT_EN to short-circuit a zero divisor
// straight to DONE; otherwise a zero divisor runs the full iteration count
// and div_by_zero is tied low.
module div_restoring_seq
  import div_restoring_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   p;
  logic [WIDTH:0]   diff;
  logic             borrow;

  // Shift the next dividend bit into the partial remainder.
  assign p = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  // R can reach 2*divisor-1, so the subtract must be WIDTH+1 bits wide.
  div_restoring_seq_sub_stage #(
    .W(WIDTH + 1)
  ) u_sub (
    .minuend    (p),
    .subtrahend ({1'b0, divisor_q}),
    .diff       (diff),
    .borrow_out (borrow)
  );

`ifdef DIV_ZERO_DETECT_EN
  logic dbz_q, dbz_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    q_d         = q_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef DIV_ZERO_DETECT_EN
    dbz_d       = dbz_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          divisor_d   = divisor;
          q_d         = dividend;
          r_d         = '0;
          cnt_d       = CNT_W'(WIDTH - 1);
          quotient_d  = '0;
          remainder_d = '0;
          state_d     = RUN;
`ifdef DIV_ZERO_DETECT_EN
          dbz_d       = 1'b0;
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end
`endif
        end
      end
      RUN: begin
        q_d = {q_q[WIDTH-2:0], ~borrow};
        r_d = borrow ? p : diff;
        if (cnt_q == '0) begin
          // Results are registered on the final iteration so they are
          // valid in the same cycle as the done pulse.
          state_d     = DONE;
          quotient_d  = q_d;
          remainder_d = r_d[WIDTH-1:0];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      q_q         <= q_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q       <= dbz_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
`ifdef DIV_ZERO_DETECT_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div_restoring_seq.sv
module tb_div_restoring_seq;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;

  div_restoring_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DIV_ZERO_DETECT_EN
  localparam int ZERO_LAT  = 0;
  localparam int ZERO_BUSY = 1;
  localparam logic ZERO_DBZ = 1'b1;
`else
  localparam int ZERO_LAT  = W;
  localparam int ZERO_BUSY = W + 1;
  localparam logic ZERO_DBZ = 1'b0;
`endif

  // Issue one start and observe W+4 cycles. lat is the cycle index (0 = the
  // cycle right after the accepting edge) of the first done pulse, -1 if none.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit inject_start,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic z, output int lat,
                        output int busy_n, output int done_n);
    q = '0; r = '0; z = 1'b0; lat = -1; busy_n = 0; done_n = 0;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat < 0) begin
          lat = k; q = quotient; r = remainder; z = div_by_zero;
        end
      end
      if (inject_start && k == 1) begin
        dividend = 4'd5; divisor = 4'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        k++;
        @(negedge clk);
        if (busy) busy_n++;
        if (done) done_n++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b q=%0d r=%0d z=%0b, need all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [W-1:0] q, r; logic z; int lat, bn, dn;
    do_div(4'd13, 4'd3, 1'b0, q, r, z, lat, bn, dn);
    checks++;
    if ({q, r, z} !== {4'd4, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL div_13_3: got q=%0d r=%0d z=%0b, need q=4 r=1 z=0", q, r, z);
    end
    checks++;
    if (lat !== W) begin
      errors++;
      $display("FAIL lat_13_3: got %0d, need %0d", lat, W);
    end
    checks++;
    if (bn !== W + 1) begin
      errors++;
      $display("FAIL busy_13_3: got %0d cycles, need %0d", bn, W + 1);
    end
    checks++;
    if (dn !== 1) begin
      errors++;
      $display("FAIL done_cnt_13_3: got %0d, need 1", dn);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [3] = '{4'd15, 4'd15, 4'd2};
    logic [W-1:0] vb [3] = '{4'd15, 4'd1, 4'd7};
    logic [W-1:0] eq [3] = '{4'd1, 4'd15, 4'd0};
    logic [W-1:0] er [3] = '{4'd0, 4'd0, 4'd2};
    logic [W-1:0] q, r; logic z; int lat, bn, dn;
    for (int i = 0; i < 3; i++) begin
      do_div(va[i], vb[i], 1'b0, q, r, z, lat, bn, dn);
      checks++;
      if ({q, r, z, lat} !== {eq[i], er[i], 1'b0, W}) begin
        errors++;
        $display("FAIL vec_%0d_%0d: got q=%0d r=%0d z=%0b lat=%0d, need q=%0d r=%0d z=0 lat=%0d",
                 va[i], vb[i], q, r, z, lat, eq[i], er[i], W);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] q, r; logic z; int lat, bn, dn;
    do_div(4'd9, 4'd0, 1'b0, q, r, z, lat, bn, dn);
    checks++;
    if ({q, r, z} !== {4'd15, 4'd9, ZERO_DBZ}) begin
      errors++;
      $display("FAIL div_9_0: got q=%0d r=%0d z=%0b, need q=15 r=9 z=%0b", q, r, z, ZERO_DBZ);
    end
    checks++;
    if (lat !== ZERO_LAT || bn !== ZERO_BUSY) begin
      errors++;
      $display("FAIL lat_9_0: got lat=%0d busy=%0d, need lat=%0d busy=%0d",
               lat, bn, ZERO_LAT, ZERO_BUSY);
    end
    // A following nonzero division must clear the sticky flag.
    do_div(4'd7, 4'd2, 1'b0, q, r, z, lat, bn, dn);
    checks++;
    if ({q, r, z} !== {4'd3, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL div_7_2_after_zero: got q=%0d r=%0d z=%0b, need q=3 r=1 z=0", q, r, z);
    end
  endtask

  task automatic test_start_while_busy();
    logic [W-1:0] q, r; logic z; int lat, bn, dn;
    do_div(4'd13, 4'd3, 1'b1, q, r, z, lat, bn, dn);
    checks++;
    if ({q, r, lat, dn} !== {4'd4, 4'd1, W, 32'sd1}) begin
      errors++;
      $display("FAIL start_busy: got q=%0d r=%0d lat=%0d dones=%0d, need q=4 r=1 lat=%0d dones=1",
               q, r, lat, dn, W);
    end
  endtask

  task automatic test_back_to_back();
    int dn = 0;
    int first = -1;
    int second = -1;
    @(negedge clk);
    dividend = 4'd6; divisor = 4'd3; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 2 * W + 6; k++) begin
      @(negedge clk);
      if (done) begin
        dn++;
        if (first < 0) first = k; else if (second < 0) second = k;
        checks++;
        if ({quotient, remainder} !== {4'd2, 4'd0}) begin
          errors++;
          $display("FAIL b2b_result: got q=%0d r=%0d, need q=2 r=0", quotient, remainder);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (dn !== 2 || first !== W || second !== 2 * W + 2) begin
      errors++;
      $display("FAIL b2b_timing: got dones=%0d at %0d,%0d, need 2 at %0d,%0d",
               dn, first, second, W, 2 * W + 2);
    end
    repeat (W + 2) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] q, r; logic z; int lat, bn, dn;
    @(negedge clk);
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: got busy=%0b done=%0b q=%0d r=%0d z=%0b, need all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    dn = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (done) dn++;
    end
    checks++;
    if (dn !== 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d done pulses, need 0", dn);
    end
    rst_n = 1'b1;
    do_div(4'd6, 4'd4, 1'b0, q, r, z, lat, bn, dn);
    checks++;
    if ({q, r, lat} !== {4'd1, 4'd2, W}) begin
      errors++;
      $display("FAIL div_6_4_after_reset: got q=%0d r=%0d lat=%0d, need q=1 r=2 lat=%0d",
               q, r, lat, W);
    end
  endtask

  task automatic test_sweep();
    logic [W-1:0] q, r; logic z; int lat, bn, dn;
    int eq, er;
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        do_div(W'(a), W'(b), 1'b0, q, r, z, lat, bn, dn);
        if (b == 0) begin eq = (1 << W) - 1; er = a; end
        else begin eq = a / b; er = a % b; end
        checks++;
        if (int'(q) != eq || int'(r) != er || lat !== ((b == 0) ? ZERO_LAT : W)) begin
          errors++;
          $display("FAIL sweep_%0d_%0d: got q=%0d r=%0d lat=%0d, need q=%0d r=%0d lat=%0d",
                   a, b, q, r, lat, eq, er, (b == 0) ? ZERO_LAT : W);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
